// File: rtl/ama_riscv_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  ama_riscv_mem_arb_pkg
//  Shared types and defaults for the unified-memory fetch/data arbiter.
//  Revision: 1.0
// ============================================================================
package ama_riscv_mem_arb_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_F = 2'd1,
    RD_D = 2'd2,
    WR_D = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    DATA = 2'd2
  } owner_t;

  // Only reads produce a response, so only they carry an owner.
  function automatic owner_t owner_of(input arb_state_t st);
    owner_t o;
    o = NONE;
    if (st == RD_F) o = IF;
    else if (st == RD_D) o = DATA;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ama_riscv_arb_sat_cnt.sv
`default_nettype none
// ============================================================================
//  ama_riscv_arb_sat_cnt
//  Saturating up-counter with synchronous clear (clear wins over increment).
//  Revision: 1.0
// ============================================================================
module ama_riscv_arb_sat_cnt #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ama_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  ama_riscv_mem_arbiter
//  Shares one single-port sync memory between fetch and data ports; data has
//  priority, fetch is forced after STARVE_LIMIT consecutive data wins.
//  Optional perf counters: define AMA_RISCV_ARB_PERF_EN.
//  Revision: 1.0
// ============================================================================
module ama_riscv_mem_arbiter
  import ama_riscv_mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_req_ready,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          d_req_valid,
  input  logic [3:0]    d_req_we,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_req_ready,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          conflict
`ifdef AMA_RISCV_ARB_PERF_EN
  ,
  output logic [31:0]   cnt_conflict,
  output logic [31:0]   cnt_if_stall,
  output logic [31:0]   cnt_starve_force
`endif
);

  localparam int              c_SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  owner_t          r_owner;
  logic [c_SW-1:0] w_streak;
  logic            w_force;
  logic            w_d_gnt;
  logic            w_if_gnt;

  // Fetch steals the slot only when data has won STARVE_LIMIT times in a row.
  assign w_force  = if_req_valid & d_req_valid & (w_streak == c_LIMIT);
  assign w_d_gnt  = d_req_valid & ~w_force;
  assign w_if_gnt = if_req_valid & ~w_d_gnt;

  assign if_req_ready = w_if_gnt;
  assign d_req_ready  = w_d_gnt;
  assign conflict     = if_req_valid & d_req_valid;

  assign mem_en   = w_if_gnt | w_d_gnt;
  assign mem_we   = w_d_gnt ? d_req_we : 4'h0;
  assign mem_addr = w_d_gnt ? d_req_addr : (w_if_gnt ? if_req_addr : '0);
  assign mem_din  = w_d_gnt ? d_req_wdata : '0;

  ama_riscv_arb_sat_cnt #(
    .W   (c_SW),
    .MAX (c_LIMIT)
  ) u_streak (
    .clk (clk),
    .rst (rst),
    .clr (w_if_gnt | ~if_req_valid),
    .inc (w_d_gnt & if_req_valid),
    .cnt (w_streak)
  );

  always_comb begin
    w_state_nxt = IDLE;
    if (w_if_gnt) begin
      w_state_nxt = RD_F;
    end else if (w_d_gnt) begin
      if (d_req_we == 4'h0) w_state_nxt = RD_D;
      else                  w_state_nxt = WR_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= NONE;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= owner_of(w_state_nxt);
    end
  end

  // Non-owner sees zeros so downstream muxing never leaks the other port's data.
  assign if_rsp_valid = (r_state == RD_F);
  assign d_rsp_valid  = (r_state == RD_D);
  assign if_rsp_data  = (r_owner == IF)   ? mem_dout : '0;
  assign d_rsp_data   = (r_owner == DATA) ? mem_dout : '0;

`ifdef AMA_RISCV_ARB_PERF_EN
  logic w_if_stall;
  assign w_if_stall = if_req_valid & ~w_if_gnt;

  ama_riscv_arb_sat_cnt #(.W(32), .MAX({32{1'b1}})) u_cnt_conflict (
    .clk (clk), .rst (rst), .clr (1'b0), .inc (conflict), .cnt (cnt_conflict)
  );

  ama_riscv_arb_sat_cnt #(.W(32), .MAX({32{1'b1}})) u_cnt_if_stall (
    .clk (clk), .rst (rst), .clr (1'b0), .inc (w_if_stall), .cnt (cnt_if_stall)
  );

  ama_riscv_arb_sat_cnt #(.W(32), .MAX({32{1'b1}})) u_cnt_starve (
    .clk (clk), .rst (rst), .clr (1'b0), .inc (w_force), .cnt (cnt_starve_force)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_ama_riscv_mem_arbiter
//  Randomised + directed bench with a behavioural memory and response scoreboard.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ama_riscv_mem_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int MEMW = 16384;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          d_req_valid, d_req_ready, d_rsp_valid;
  logic [3:0]    d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_rsp_data;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          conflict;
`ifdef AMA_RISCV_ARB_PERF_EN
  logic [31:0]   cnt_conflict, cnt_if_stall, cnt_starve_force;
`endif

  ama_riscv_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .d_req_valid  (d_req_valid),
    .d_req_we     (d_req_we),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_req_ready  (d_req_ready),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_data   (d_rsp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .conflict     (conflict)
`ifdef AMA_RISCV_ARB_PERF_EN
    ,
    .cnt_conflict     (cnt_conflict),
    .cnt_if_stall     (cnt_if_stall),
    .cnt_starve_force (cnt_starve_force)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural single-port BRAM, one-cycle read latency.
  logic [DW-1:0] bram [0:MEMW-1];
  initial begin
    mem_dout = '0;
    for (int i = 0; i < MEMW; i++) bram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        mem_dout <= bram[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) bram[mem_addr][8*b +: 8] = mem_din[8*b +: 8];
      end
    end
  end

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t          if_q[$];
  exp_t          d_q[$];
  logic [DW-1:0] ref_mem [0:MEMW-1];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            streak_m = 0;

  bit            f_pend, d_pend;
  logic [AW-1:0] f_addr_p, d_addr_p;
  logic [3:0]    d_we_p;
  logic [DW-1:0] d_wd_p;
  logic          last_if_ready;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: pops expected responses when due, otherwise requires silence.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (if_q.size() != 0 && if_q[0].due == cyc) begin
        mon_e = if_q.pop_front();
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        chk("if_rsp_data", if_rsp_data, mon_e.data);
      end else begin
        chk("if_rsp_idle", 32'(if_rsp_valid), 32'd0);
        chk("if_rsp_data_zero", if_rsp_data, 32'd0);
      end
      if (d_q.size() != 0 && d_q[0].due == cyc) begin
        mon_e = d_q.pop_front();
        chk("d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        chk("d_rsp_data", d_rsp_data, mon_e.data);
      end else begin
        chk("d_rsp_idle", 32'(d_rsp_valid), 32'd0);
        chk("d_rsp_data_zero", d_rsp_data, 32'd0);
      end
    end
  end

  task automatic drive_ports();
    if_req_valid = f_pend;
    if_req_addr  = f_pend ? f_addr_p : '0;
    d_req_valid  = d_pend;
    d_req_we     = d_pend ? d_we_p : 4'h0;
    d_req_addr   = d_pend ? d_addr_p : '0;
    d_req_wdata  = d_pend ? d_wd_p : '0;
  endtask

  // One clock: drive pending requests, check grant against the model, score.
  task automatic step();
    bit   ef, ed;
    exp_t e;
    drive_ports();
    @(negedge clk);
    ef = f_pend && (!d_pend || streak_m >= LIM);
    ed = d_pend && !ef;
    last_if_ready = if_req_ready;
    chk("if_req_ready", 32'(if_req_ready), 32'(ef));
    chk("d_req_ready", 32'(d_req_ready), 32'(ed));
    chk("conflict", 32'(conflict), 32'(f_pend && d_pend));
    chk("mem_en", 32'(mem_en), 32'(ef || ed));
    chk("mem_we", 32'(mem_we), ed ? 32'(d_we_p) : 32'd0);
    if (ef) chk("mem_addr_if", 32'(mem_addr), 32'(f_addr_p));
    if (ed) chk("mem_addr_d", 32'(mem_addr), 32'(d_addr_p));
    if (ed && d_we_p != 4'h0) chk("mem_din", mem_din, d_wd_p);
    if (ed && f_pend) streak_m = (streak_m < LIM) ? streak_m + 1 : LIM;
    else              streak_m = 0;
    if (ef) begin
      e.due = cyc + 1; e.data = ref_mem[f_addr_p];
      if_q.push_back(e);
      f_pend = 0;
    end
    if (ed) begin
      if (d_we_p == 4'h0) begin
        e.due = cyc + 1; e.data = ref_mem[d_addr_p];
        d_q.push_back(e);
      end else begin
        for (int b = 0; b < 4; b++)
          if (d_we_p[b]) ref_mem[d_addr_p][8*b +: 8] = d_wd_p[8*b +: 8];
      end
      d_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_window(input bit async_mid);
    if (async_mid) #2;
    rst = 1'b1;
    f_pend = 0; d_pend = 0; streak_m = 0;
    drive_ports();
    if_q.delete(); d_q.delete();
    @(negedge clk);
    chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_if_rsp_data", if_rsp_data, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ready", 32'({if_req_ready, d_req_ready}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic req_d(input logic [3:0] we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_pend = 1; d_we_p = we; d_addr_p = a; d_wd_p = wd;
  endtask

  int fgr[$];

  initial begin
    for (int i = 0; i < MEMW; i++) ref_mem[i] = init_word(i);
    f_pend = 0; d_pend = 0; f_addr_p = '0; d_addr_p = '0; d_we_p = '0; d_wd_p = '0;
    reset_window(1'b0);

    // Fetch stream, one word per cycle.
    for (int i = 0; i < 4; i++) begin
      f_pend = 1; f_addr_p = AW'(14'h0010 + i);
      step();
    end
    step();

    // Full store then load of the same word.
    req_d(4'hF, 14'h0200, 32'hDEAD_BEEF); step();
    req_d(4'h0, 14'h0200, '0);            step();
    step();

    // Partial store merges with the existing bytes.
    req_d(4'hF, 14'h0300, 32'h1122_3344); step();
    req_d(4'b0011, 14'h0300, 32'h0000_ABCD); step();
    req_d(4'h0, 14'h0300, '0); step();
    step();

    // Async reset while a fetch response is in flight.
    f_pend = 1; f_addr_p = 14'h0020; step();
    reset_window(1'b1);
    f_pend = 1; f_addr_p = 14'h0021; step();
    step();

    // Both valid continuously: data wins four times, then fetch is forced.
    for (int i = 0; i < 10; i++) begin
      if (!f_pend) begin f_pend = 1; f_addr_p = AW'($urandom_range(0, 31)); end
      if (!d_pend) req_d(4'h0, AW'($urandom_range(0, 31)), '0);
      step();
      if (last_if_ready) fgr.push_back(i);
    end
    chk("starve_fetch_grants", 32'(fgr.size()), 32'd2);
    if (fgr.size() == 2) begin
      chk("starve_first_fetch", 32'(fgr[0]), 32'd4);
      chk("starve_second_fetch", 32'(fgr[1]), 32'd9);
    end
    f_pend = 0; d_pend = 0;
    step();
`ifdef AMA_RISCV_ARB_PERF_EN
    chk("cnt_conflict", cnt_conflict, 32'd10);
    chk("cnt_starve_force", cnt_starve_force, 32'd2);
    chk("cnt_if_stall", cnt_if_stall, 32'd8);
`endif

    // Random traffic with held requests.
    for (int i = 0; i < 500; i++) begin
      if (!f_pend && $urandom_range(0, 9) < 7) begin
        f_pend = 1; f_addr_p = AW'($urandom_range(0, 31));
      end
      if (!d_pend && $urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 1) == 0) req_d(4'h0, AW'($urandom_range(0, 31)), '0);
        else req_d(4'($urandom_range(1, 15)), AW'($urandom_range(0, 31)), $urandom);
      end
      step();
    end

    f_pend = 0; d_pend = 0;
    step(); step(); step();
    chk("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk("d_queue_drained", 32'(d_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
